hbm_rd_dispatch: RTL and testbench
==================================

# hbm_rd_dispatch

Read-data stage directly downstream of the HBM read-address generator. It accepts the AXI read-data (R) channel of one HBM pseudo-channel and steers each beat by RID tag into a sample stream (A, tag `MEM_RD_A_TAG`) or a label stream (B, tag `MEM_RD_B_TAG`). Each stream is buffered in its own FWFT FIFO. The block also tracks outstanding bursts against the generator's AR handshakes and signals when an epoch's reads have fully drained into the SGD engine.

## Interface
- DATA_WIDTH, 256, R beat and stream width
- ID_WIDTH, 6, RID width
- FIFO_DEPTH, 16, entries per stream FIFO (power of 2)
- hbm_clk  in  1  clock
- hbm_aresetn  in  1  asynchronous active-low reset
- start  in  1  level; begins a run from IDLE
- ar_fire  in  1  generator's ARVALID&ARREADY
- rd_addr_done  in  1  generator's address-issue-complete flag
- m_axi_RVALID / m_axi_RREADY  in / out  1  R handshake
- m_axi_RDATA  in  DATA_WIDTH
- m_axi_RID  in  ID_WIDTH
- m_axi_RRESP  in  2
- m_axi_RLAST  in  1
- a_data / a_valid / a_ready  out/out/in  DATA_WIDTH/1/1  sample stream
- b_data / b_valid / b_ready  out/out/in  DATA_WIDTH/1/1  label stream
- outstanding  out  16  bursts issued but not yet RLAST-accepted
- a_beat_cnt, b_beat_cnt  out  32  beats accepted per stream since start
- rd_data_done  out  1  one-cycle pulse at end of run
- rd_err  out  1  sticky protocol error

## Operation
- m_axi_RREADY = !full of FIFO selected by RID (combinational on RID); unknown RID → RREADY=1, beat dropped, error condition.
- Accepted beat (RVALID&RREADY) pushes RDATA to the selected FIFO; the matching beat counter increments.
- outstanding: +1 on ar_fire, -1 on accepted RLAST beat; both in the same cycle → unchanged; decrement at 0 saturates at 0 (error condition).
- FSM states IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN when start=1; the entry cycle clears beat counters, outstanding, and rd_err.
  - RUN→DRAIN when rd_addr_done=1.
  - DRAIN→DONE when outstanding==0 and both FIFOs are empty.
  - DONE→IDLE unconditionally; rd_data_done=1 only in DONE.
- Beat routing and FIFO operation are state-independent; beats accepted in IDLE are still routed.
- Per-tag 2-bit beat index, wraps after 4 beats (ARLEN=3); resets on accepted RLAST.

## Timing
- Reset: RREADY 0 while in reset, then follows FIFO state; a_valid, b_valid 0; outstanding 0; beat counters 0; rd_data_done 0; rd_err 0; FSM in IDLE; FIFOs empty.
- Beat accepted at edge N → visible on a/b_data with valid at N+1 (FWFT, registered storage).
- Full FIFO: RREADY low for that tag even when a pop happens in the same cycle (no bypass). Push and pop in the same non-full cycle → occupancy unchanged.
- Stream handshake: data is stable while valid&!ready; pop on valid&ready.
- Counters wrap modulo 2^32.
- Async reset mid-burst discards FIFO contents and the partial beat index.

## Configuration
- HBM_RD_ERR_CHECK_EN defined: rd_err sets, and stays set until the next run start, on any of:
  - RRESP≠0;
  - RLAST≠(beat_index==3);
  - unknown RID;
  - outstanding underflow.
- Not defined: rd_err tied 0; checker logic absent; routing is unchanged.

## Structure
- Shared package sgd_pkg: MEM_RD_A_TAG, MEM_RD_B_TAG, HBM_BURST_BEATS=4, FSM state enum.
- Sub-module hbm_rd_fifo: sync FWFT FIFO with full/empty outputs, instantiated twice.

## Test plan
- Start; 3 ar_fire; return 3 four-beat bursts (2 A, 1 B), ready=1 → a_beat_cnt=8, b_beat_cnt=4, outstanding 3→0. rd_addr_done then gives one rd_data_done pulse after both FIFOs empty.
- a_ready=0 with 16 A beats pushed → RREADY=0 for A tag while B beats still accepted; a_ready=1 → A beats resume, order preserved.
- ar_fire and accepted RLAST in the same cycle with outstanding=5 → stays 5.
- Macro on: RLAST on beat 2, or RRESP=2'b10 → rd_err=1 until next start. Macro off: same stimulus → rd_err=0.
- Reset asserted mid-burst with 10 beats buffered → a_valid=b_valid=0, outstanding=0, FSM IDLE on the next edge.
- Interleaved A/B bursts beat-by-beat → each stream receives its own 4 beats in order, no cross-routing.

Source files
------------

// File: rtl/sgd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sgd_pkg
//  Description : Shared constants and types for the SGD memory-read path.
//                RID tags that steer HBM read data into the sample (A) and
//                label (B) streams, the fixed burst length, and the read
//                dispatch FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package sgd_pkg;

    // RID tags issued by the read-address generator
    localparam int MEM_RD_A_TAG    = 0;
    localparam int MEM_RD_B_TAG    = 1;

    // Beats per HBM read burst (ARLEN = 3)
    localparam int HBM_BURST_BEATS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage : sgd_pkg
`default_nettype wire

// File: rtl/hbm_rd_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_rd_dispatch_if
//  Description : AXI read-data channel of one HBM pseudo-channel together
//                with the two outgoing valid/ready streams (A = samples,
//                B = labels).
//                master : HBM side / stream sinks (drives R, consumes A/B)
//                slave  : dispatch side (accepts R, sources A/B)
//  Parameters  : DATA_WIDTH - R beat and stream width
//                ID_WIDTH   - RID width
//  Revision    : 1.0  initial release
// ============================================================================
interface hbm_rd_dispatch_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 6
);
    logic                  m_axi_RVALID;
    logic                  m_axi_RREADY;
    logic [DATA_WIDTH-1:0] m_axi_RDATA;
    logic [ID_WIDTH-1:0]   m_axi_RID;
    logic [1:0]            m_axi_RRESP;
    logic                  m_axi_RLAST;

    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_valid;
    logic                  a_ready;

    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_valid;
    logic                  b_ready;

    modport master (
        output m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RRESP, m_axi_RLAST,
        input  m_axi_RREADY,
        input  a_data, a_valid,
        output a_ready,
        input  b_data, b_valid,
        output b_ready
    );

    modport slave (
        input  m_axi_RVALID, m_axi_RDATA, m_axi_RID, m_axi_RRESP, m_axi_RLAST,
        output m_axi_RREADY,
        output a_data, a_valid,
        input  a_ready,
        output b_data, b_valid,
        input  b_ready
    );
endinterface : hbm_rd_dispatch_if
`default_nettype wire

// File: rtl/hbm_rd_dispatch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_rd_fifo
//  Description : Synchronous first-word-fall-through FIFO with registered
//                storage. The head entry is presented on pop_data whenever
//                empty is low; a push is visible on the cycle after it is
//                written. Pushes while full and pops while empty are ignored.
//  Ports       : clk, rst_n        - clock, asynchronous active-low reset
//                push, push_data   - write side
//                full              - no free entry
//                pop, pop_data     - read side (head of queue)
//                empty             - no valid entry
//  Parameters  : WIDTH - entry width; DEPTH - entries (power of 2, >= 2)
//  Revision    : 1.0  initial release
// ============================================================================
module hbm_rd_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  full,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] pop_data,
    output logic                  empty
);
    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign full     = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage carries no reset: contents are meaningless once the pointers
    // are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule : hbm_rd_fifo
`default_nettype wire

// File: rtl/hbm_rd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_rd_dispatch
//  Description : HBM read-data dispatch. Steers each accepted R beat by RID
//                into the sample (A) or label (B) FWFT FIFO, tracks bursts
//                outstanding between AR handshakes and RLAST, and pulses
//                rd_data_done once an epoch's reads have fully drained.
//  Ports       : hbm_clk, hbm_aresetn - clock, async active-low reset
//                start                - begins a run from IDLE (level)
//                ar_fire              - generator ARVALID & ARREADY
//                rd_addr_done         - generator finished issuing addresses
//                bus (slave)          - R channel in, A/B streams out
//                outstanding          - bursts issued, RLAST not yet seen
//                a_beat_cnt/b_beat_cnt- beats accepted per stream since start
//                rd_data_done         - one-cycle end-of-run pulse
//                rd_err               - sticky protocol error
//  Config      : HBM_RD_ERR_CHECK_EN - when defined, builds the protocol
//                checker behind rd_err; otherwise rd_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module hbm_rd_dispatch
    import sgd_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic        hbm_clk,
    input  wire logic        hbm_aresetn,
    input  wire logic        start,
    input  wire logic        ar_fire,
    input  wire logic        rd_addr_done,
    hbm_rd_dispatch_if.slave bus,
    output logic [15:0]      outstanding,
    output logic [31:0]      a_beat_cnt,
    output logic [31:0]      b_beat_cnt,
    output logic             rd_data_done,
    output logic             rd_err
);
    rd_state_e r_state;
    rd_state_e w_state_next;
    logic      w_run_start;

    logic      w_is_a;
    logic      w_is_b;
    logic      w_unknown_id;
    logic      w_a_full;
    logic      w_b_full;
    logic      w_a_empty;
    logic      w_b_empty;
    logic      w_accept;
    logic      w_a_push;
    logic      w_b_push;
    logic      w_last_acc;

    logic [DATA_WIDTH-1:0] w_a_data;
    logic [DATA_WIDTH-1:0] w_b_data;

    logic [1:0]  r_a_beat_idx;
    logic [1:0]  r_b_beat_idx;
    logic [15:0] r_outstanding;
    logic [31:0] r_a_beat_cnt;
    logic [31:0] r_b_beat_cnt;

    // ------------------------------------------------------------------
    // Routing
    // ------------------------------------------------------------------
    assign w_is_a       = (bus.m_axi_RID == ID_WIDTH'(MEM_RD_A_TAG));
    assign w_is_b       = (bus.m_axi_RID == ID_WIDTH'(MEM_RD_B_TAG));
    assign w_unknown_id = ~w_is_a & ~w_is_b;

    // Ready follows the FIFO selected by RID. An unknown RID is always
    // accepted so a stray beat cannot stall the channel; it is dropped.
    // Held low throughout reset.
    assign bus.m_axi_RREADY = hbm_aresetn &
                              (w_is_a ? ~w_a_full :
                               w_is_b ? ~w_b_full : 1'b1);

    assign w_accept   = bus.m_axi_RVALID & bus.m_axi_RREADY;
    assign w_a_push   = w_accept & w_is_a;
    assign w_b_push   = w_accept & w_is_b;
    assign w_last_acc = w_accept & bus.m_axi_RLAST;

    hbm_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk       (hbm_clk),
        .rst_n     (hbm_aresetn),
        .push      (w_a_push),
        .push_data (bus.m_axi_RDATA),
        .full      (w_a_full),
        .pop       (bus.a_ready),
        .pop_data  (w_a_data),
        .empty     (w_a_empty)
    );

    hbm_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk       (hbm_clk),
        .rst_n     (hbm_aresetn),
        .push      (w_b_push),
        .push_data (bus.m_axi_RDATA),
        .full      (w_b_full),
        .pop       (bus.b_ready),
        .pop_data  (w_b_data),
        .empty     (w_b_empty)
    );

    assign bus.a_data  = w_a_data;
    assign bus.a_valid = ~w_a_empty;
    assign bus.b_data  = w_b_data;
    assign bus.b_valid = ~w_b_empty;

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run_start  = 1'b0;
        rd_data_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_run_start  = 1'b1;
                end
            end
            ST_RUN: begin
                if (rd_addr_done) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_outstanding == 16'd0) && w_a_empty && w_b_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                rd_data_done = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding bursts and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_outstanding <= '0;
            r_a_beat_cnt  <= '0;
            r_b_beat_cnt  <= '0;
        end else if (w_run_start) begin
            r_outstanding <= '0;
            r_a_beat_cnt  <= '0;
            r_b_beat_cnt  <= '0;
        end else begin
            // Issue and completion in one cycle cancel; a completion with
            // nothing outstanding holds at zero.
            if (ar_fire && !w_last_acc) begin
                r_outstanding <= r_outstanding + 16'd1;
            end else if (!ar_fire && w_last_acc && (r_outstanding != 16'd0)) begin
                r_outstanding <= r_outstanding - 16'd1;
            end
            if (w_a_push) begin
                r_a_beat_cnt <= r_a_beat_cnt + 32'd1;
            end
            if (w_b_push) begin
                r_b_beat_cnt <= r_b_beat_cnt + 32'd1;
            end
        end
    end

    assign outstanding = r_outstanding;
    assign a_beat_cnt  = r_a_beat_cnt;
    assign b_beat_cnt  = r_b_beat_cnt;

    // Position of the next beat within the current burst, per tag.
    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_a_beat_idx <= '0;
            r_b_beat_idx <= '0;
        end else begin
            if (w_a_push) begin
                r_a_beat_idx <= bus.m_axi_RLAST ? 2'd0 : r_a_beat_idx + 2'd1;
            end
            if (w_b_push) begin
                r_b_beat_idx <= bus.m_axi_RLAST ? 2'd0 : r_b_beat_idx + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef HBM_RD_ERR_CHECK_EN
    logic [1:0] w_cur_beat_idx;
    logic       w_underflow;
    logic       w_err_event;
    logic       r_rd_err;

    assign w_cur_beat_idx = w_is_b ? r_b_beat_idx : r_a_beat_idx;
    assign w_underflow    = w_last_acc & ~ar_fire & (r_outstanding == 16'd0);

    // RLAST must mark exactly the final beat of a burst on a known tag.
    assign w_err_event = (w_accept &
                          ((bus.m_axi_RRESP != 2'b00) |
                           w_unknown_id |
                           (~w_unknown_id &
                            (bus.m_axi_RLAST !=
                             (w_cur_beat_idx == 2'(HBM_BURST_BEATS - 1)))))) |
                         w_underflow;

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            r_rd_err <= 1'b0;
        end else if (w_run_start) begin
            r_rd_err <= 1'b0;
        end else if (w_err_event) begin
            r_rd_err <= 1'b1;
        end
    end

    assign rd_err = r_rd_err;
`else
    logic w_unused_chk;
    assign w_unused_chk = &{1'b0, bus.m_axi_RRESP, w_unknown_id,
                            r_a_beat_idx, r_b_beat_idx};
    assign rd_err = 1'b0;
`endif

endmodule : hbm_rd_dispatch
`default_nettype wire

// File: tb/tb_hbm_rd_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hbm_rd_dispatch
//  Description : Self-checking bench for hbm_rd_dispatch. Accepted beats are
//                pushed to per-stream expected queues; stream monitors pop
//                and compare whenever a beat leaves a stream. Honours
//                HBM_RD_ERR_CHECK_EN for the expected rd_err value.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hbm_rd_dispatch;
    import sgd_pkg::*;

    localparam int DW    = 256;
    localparam int IW    = 6;
    localparam int DEPTH = 16;

    logic        hbm_clk = 1'b0;
    logic        hbm_aresetn;
    logic        start;
    logic        ar_fire;
    logic        rd_addr_done;
    logic [15:0] outstanding;
    logic [31:0] a_beat_cnt;
    logic [31:0] b_beat_cnt;
    logic        rd_data_done;
    logic        rd_err;

    hbm_rd_dispatch_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    hbm_rd_dispatch #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .hbm_clk      (hbm_clk),
        .hbm_aresetn  (hbm_aresetn),
        .start        (start),
        .ar_fire      (ar_fire),
        .rd_addr_done (rd_addr_done),
        .bus          (bus),
        .outstanding  (outstanding),
        .a_beat_cnt   (a_beat_cnt),
        .b_beat_cnt   (b_beat_cnt),
        .rd_data_done (rd_data_done),
        .rd_err       (rd_err)
    );

    always #5 hbm_clk = ~hbm_clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];
    logic [DW-1:0] mon_a_exp;
    logic [DW-1:0] mon_b_exp;

    logic exp_err;
`ifdef HBM_RD_ERR_CHECK_EN
    initial exp_err = 1'b1;
`else
    initial exp_err = 1'b0;
`endif

    // ---------------- stream monitors (scoreboard pop side) ----------------
    always @(negedge hbm_clk) begin
        if (hbm_aresetn && bus.a_valid && bus.a_ready) begin
            n_total++;
            if (exp_a.size() == 0) begin
                $display("FAIL a_stream_extra: got %h, required no beat", bus.a_data);
            end else begin
                mon_a_exp = exp_a.pop_front();
                if (bus.a_data !== mon_a_exp)
                    $display("FAIL a_stream_data: got %h, required %h", bus.a_data, mon_a_exp);
                else
                    n_pass++;
            end
        end
    end

    always @(negedge hbm_clk) begin
        if (hbm_aresetn && bus.b_valid && bus.b_ready) begin
            n_total++;
            if (exp_b.size() == 0) begin
                $display("FAIL b_stream_extra: got %h, required no beat", bus.b_data);
            end else begin
                mon_b_exp = exp_b.pop_front();
                if (bus.b_data !== mon_b_exp)
                    $display("FAIL b_stream_data: got %h, required %h", bus.b_data, mon_b_exp);
                else
                    n_pass++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send_beat(input int tag, input logic last, input logic [1:0] resp,
                             input logic with_ar);
        logic [DW-1:0] d;
        int n;
        d = rand_data();
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b1;
        bus.m_axi_RID    = IW'(tag);
        bus.m_axi_RDATA  = d;
        bus.m_axi_RLAST  = last;
        bus.m_axi_RRESP  = resp;
        n = 0;
        @(negedge hbm_clk);
        while (!bus.m_axi_RREADY && n < 200) begin
            @(negedge hbm_clk);
            n++;
        end
        n_total++;
        if (!bus.m_axi_RREADY) begin
            $display("FAIL beat_accept_timeout: RREADY got %b, required 1 (tag %0d)", bus.m_axi_RREADY, tag);
        end else begin
            n_pass++;
            ar_fire = with_ar;
            if (tag == MEM_RD_A_TAG) exp_a.push_back(d);
            else if (tag == MEM_RD_B_TAG) exp_b.push_back(d);
        end
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b0;
        bus.m_axi_RLAST  = 1'b0;
        bus.m_axi_RRESP  = 2'b00;
        ar_fire          = 1'b0;
    endtask

    task automatic send_burst(input int tag, input logic ar_on_last);
        for (int i = 0; i < HBM_BURST_BEATS; i++)
            send_beat(tag, (i == HBM_BURST_BEATS - 1), 2'b00, ar_on_last && (i == HBM_BURST_BEATS - 1));
    endtask

    task automatic issue_ar(input int n);
        repeat (n) begin
            @(posedge hbm_clk); #1;
            ar_fire = 1'b1;
        end
        @(posedge hbm_clk); #1;
        ar_fire = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge hbm_clk); #1; start = 1'b1;
        @(posedge hbm_clk); #1; start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
            @(negedge hbm_clk);
            n++;
        end
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL drain_timeout: pending got a=%0d b=%0d, required 0", exp_a.size(), exp_b.size());
        else
            n_pass++;
    endtask

    // Raise rd_addr_done and count rd_data_done cycles over a fixed window.
    task automatic finish_run(input int exp_pulses);
        int pulses;
        @(posedge hbm_clk); #1; rd_addr_done = 1'b1;
        @(posedge hbm_clk); #1; rd_addr_done = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge hbm_clk);
            if (rd_data_done) pulses++;
        end
        n_total++;
        if (pulses != exp_pulses)
            $display("FAIL done_pulse: got %0d cycles, required %0d", pulses, exp_pulses);
        else
            n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hbm_aresetn = 1'b0;
        repeat (3) @(posedge hbm_clk);
        @(negedge hbm_clk);
        n_total++; if (bus.m_axi_RREADY !== 1'b0) $display("FAIL reset_rready: got %b, required 0", bus.m_axi_RREADY); else n_pass++;
        n_total++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) $display("FAIL reset_valid: got a=%b b=%b, required 0 0", bus.a_valid, bus.b_valid); else n_pass++;
        n_total++; if (outstanding !== 16'd0) $display("FAIL reset_outstanding: got %0d, required 0", outstanding); else n_pass++;
        n_total++; if (a_beat_cnt !== 32'd0 || b_beat_cnt !== 32'd0) $display("FAIL reset_cnt: got a=%0d b=%0d, required 0 0", a_beat_cnt, b_beat_cnt); else n_pass++;
        n_total++; if (rd_data_done !== 1'b0 || rd_err !== 1'b0) $display("FAIL reset_flags: got done=%b err=%b, required 0 0", rd_data_done, rd_err); else n_pass++;
        @(posedge hbm_clk); #1; hbm_aresetn = 1'b1;
        @(negedge hbm_clk);
        n_total++; if (bus.m_axi_RREADY !== 1'b1) $display("FAIL post_reset_rready: got %b, required 1", bus.m_axi_RREADY); else n_pass++;
    endtask

    task automatic test_basic_run();
        pulse_start();
        issue_ar(3);
        @(negedge hbm_clk);
        n_total++; if (outstanding !== 16'd3) $display("FAIL basic_outstanding_issued: got %0d, required 3", outstanding); else n_pass++;
        send_burst(MEM_RD_A_TAG, 1'b0);
        send_burst(MEM_RD_B_TAG, 1'b0);
        send_burst(MEM_RD_A_TAG, 1'b0);
        wait_drain();
        n_total++; if (a_beat_cnt !== 32'd8) $display("FAIL basic_a_cnt: got %0d, required 8", a_beat_cnt); else n_pass++;
        n_total++; if (b_beat_cnt !== 32'd4) $display("FAIL basic_b_cnt: got %0d, required 4", b_beat_cnt); else n_pass++;
        n_total++; if (outstanding !== 16'd0) $display("FAIL basic_outstanding_drained: got %0d, required 0", outstanding); else n_pass++;
        n_total++; if (rd_err !== 1'b0) $display("FAIL basic_rd_err: got %b, required 0", rd_err); else n_pass++;
        finish_run(1);
    endtask

    task automatic test_backpressure();
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b1;
        repeat (DEPTH / HBM_BURST_BEATS) send_burst(MEM_RD_A_TAG, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (bus.a_valid !== 1'b1) $display("FAIL bp_a_valid: got %b, required 1", bus.a_valid); else n_pass++;
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b1;
        bus.m_axi_RID    = IW'(MEM_RD_A_TAG);
        bus.m_axi_RDATA  = rand_data();
        @(negedge hbm_clk);
        n_total++; if (bus.m_axi_RREADY !== 1'b0) $display("FAIL bp_full_rready: got %b, required 0", bus.m_axi_RREADY); else n_pass++;
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b0;
        send_burst(MEM_RD_B_TAG, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (b_beat_cnt !== 32'd8) $display("FAIL bp_b_cnt: got %0d, required 8", b_beat_cnt); else n_pass++;
        // Full with a pop in the same cycle: still no room this cycle.
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b1;
        bus.m_axi_RID    = IW'(MEM_RD_A_TAG);
        bus.a_ready      = 1'b1;
        @(negedge hbm_clk);
        n_total++; if (bus.m_axi_RREADY !== 1'b0) $display("FAIL bp_full_pop_rready: got %b, required 0", bus.m_axi_RREADY); else n_pass++;
        @(posedge hbm_clk); #1;
        bus.m_axi_RVALID = 1'b0;
        send_burst(MEM_RD_A_TAG, 1'b0);
        wait_drain();
        n_total++; if (a_beat_cnt !== 32'd28) $display("FAIL bp_a_cnt: got %0d, required 28", a_beat_cnt); else n_pass++;
    endtask

    task automatic test_same_cycle();
        pulse_start();
        issue_ar(5);
        @(negedge hbm_clk);
        n_total++; if (outstanding !== 16'd5) $display("FAIL same_pre: got %0d, required 5", outstanding); else n_pass++;
        send_burst(MEM_RD_A_TAG, 1'b1);
        @(negedge hbm_clk);
        n_total++; if (outstanding !== 16'd5) $display("FAIL same_cycle_ar_rlast: got %0d, required 5", outstanding); else n_pass++;
        send_burst(MEM_RD_B_TAG, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (outstanding !== 16'd4) $display("FAIL same_dec: got %0d, required 4", outstanding); else n_pass++;
        n_total++; if (rd_err !== 1'b0) $display("FAIL same_rd_err: got %b, required 0", rd_err); else n_pass++;
    endtask

    task automatic test_err();
        // Early RLAST on the third beat.
        send_beat(MEM_RD_A_TAG, 1'b0, 2'b00, 1'b0);
        send_beat(MEM_RD_A_TAG, 1'b0, 2'b00, 1'b0);
        send_beat(MEM_RD_A_TAG, 1'b1, 2'b00, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (rd_err !== exp_err) $display("FAIL err_early_rlast: got %b, required %b", rd_err, exp_err); else n_pass++;
        repeat (3) send_burst(MEM_RD_A_TAG, 1'b0);
        wait_drain();
        finish_run(1);
        n_total++; if (rd_err !== exp_err) $display("FAIL err_sticky: got %b, required %b", rd_err, exp_err); else n_pass++;
        pulse_start();
        @(negedge hbm_clk);
        n_total++; if (rd_err !== 1'b0) $display("FAIL err_clear_on_start: got %b, required 0", rd_err); else n_pass++;
        // Error response on an otherwise well-formed burst.
        issue_ar(1);
        send_beat(MEM_RD_B_TAG, 1'b0, 2'b10, 1'b0);
        send_beat(MEM_RD_B_TAG, 1'b0, 2'b00, 1'b0);
        send_beat(MEM_RD_B_TAG, 1'b0, 2'b00, 1'b0);
        send_beat(MEM_RD_B_TAG, 1'b1, 2'b00, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (rd_err !== exp_err) $display("FAIL err_rresp: got %b, required %b", rd_err, exp_err); else n_pass++;
        wait_drain();
        finish_run(1);
    endtask

    task automatic test_interleaved();
        pulse_start();
        issue_ar(2);
        for (int i = 0; i < HBM_BURST_BEATS; i++) begin
            send_beat(MEM_RD_A_TAG, (i == HBM_BURST_BEATS - 1), 2'b00, 1'b0);
            send_beat(MEM_RD_B_TAG, (i == HBM_BURST_BEATS - 1), 2'b00, 1'b0);
        end
        wait_drain();
        n_total++; if (a_beat_cnt !== 32'd4 || b_beat_cnt !== 32'd4) $display("FAIL inter_cnt: got a=%0d b=%0d, required 4 4", a_beat_cnt, b_beat_cnt); else n_pass++;
        n_total++; if (outstanding !== 16'd0) $display("FAIL inter_outstanding: got %0d, required 0", outstanding); else n_pass++;
        n_total++; if (rd_err !== 1'b0) $display("FAIL inter_rd_err: got %b, required 0", rd_err); else n_pass++;
        finish_run(1);
    endtask

    task automatic test_reset_mid();
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        issue_ar(3);
        send_burst(MEM_RD_A_TAG, 1'b0);
        send_beat(MEM_RD_A_TAG, 1'b0, 2'b00, 1'b0);
        send_beat(MEM_RD_A_TAG, 1'b0, 2'b00, 1'b0);
        send_burst(MEM_RD_B_TAG, 1'b0);
        @(negedge hbm_clk);
        n_total++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) $display("FAIL mid_buffered: got a=%b b=%b, required 1 1", bus.a_valid, bus.b_valid); else n_pass++;
        n_total++; if (outstanding !== 16'd1) $display("FAIL mid_outstanding: got %0d, required 1", outstanding); else n_pass++;
        #2 hbm_aresetn = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(posedge hbm_clk); #1;
        n_total++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) $display("FAIL mid_reset_valid: got a=%b b=%b, required 0 0", bus.a_valid, bus.b_valid); else n_pass++;
        n_total++; if (outstanding !== 16'd0 || a_beat_cnt !== 32'd0) $display("FAIL mid_reset_state: got out=%0d a=%0d, required 0 0", outstanding, a_beat_cnt); else n_pass++;
        @(posedge hbm_clk); #1;
        hbm_aresetn = 1'b1;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        issue_ar(1);
        send_burst(MEM_RD_A_TAG, 1'b0);
        wait_drain();
        n_total++; if (rd_err !== 1'b0) $display("FAIL mid_idx_cleared: got rd_err %b, required 0", rd_err); else n_pass++;
        n_total++; if (a_beat_cnt !== 32'd4) $display("FAIL mid_a_cnt: got %0d, required 4", a_beat_cnt); else n_pass++;
        // FSM must be idle: rd_addr_done alone produces no completion.
        finish_run(0);
    endtask

    initial begin
        hbm_aresetn      = 1'b0;
        start            = 1'b0;
        ar_fire          = 1'b0;
        rd_addr_done     = 1'b0;
        bus.m_axi_RVALID = 1'b0;
        bus.m_axi_RDATA  = '0;
        bus.m_axi_RID    = IW'(MEM_RD_A_TAG);
        bus.m_axi_RRESP  = 2'b00;
        bus.m_axi_RLAST  = 1'b0;
        bus.a_ready      = 1'b1;
        bus.b_ready      = 1'b1;

        test_reset();
        test_basic_run();
        test_backpressure();
        test_same_cycle();
        test_err();
        test_interleaved();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule : tb_hbm_rd_dispatch
`default_nettype wire
